// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared card constants, slot indices and card helpers
package baccarat_pkg;
  localparam int CARD_W = 4;
  localparam int NUM_SLOTS = 6;
  localparam logic [CARD_W-1:0] CARD_ACE = 4'd1;
  localparam logic [CARD_W-1:0] CARD_TEN = 4'd10;
  localparam logic [CARD_W-1:0] CARD_KING = 4'd13;
  typedef enum logic [2:0] {P1, P2, P3, D1, D2, D3} slot_e;
  function automatic logic [3:0] card_value(input logic [CARD_W-1:0] c);
    return (c >= CARD_ACE && c < CARD_TEN) ? 4'(c) : 4'd0;
  endfunction
  function automatic logic card_illegal(input logic [CARD_W-1:0] c);
    return c < CARD_ACE || c > CARD_KING;
  endfunction
  function automatic logic [2:0] popcount(input logic [NUM_SLOTS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_SLOTS; i++) popcount += 3'(v[i]);
  endfunction
endpackage

// File: rtl/hand_score.sv
// hand_score: mod-10 baccarat score of three card codes plus out-of-range flag
module hand_score
  import baccarat_pkg::*;
(
  input  logic [CARD_W-1:0] c1_i,
  input  logic [CARD_W-1:0] c2_i,
  input  logic [CARD_W-1:0] c3_i,
  output logic [3:0]        score_o,
  output logic              illegal_o
);
  logic [4:0] sum;
  assign sum = 5'(card_value(c1_i)) + 5'(card_value(c2_i)) + 5'(card_value(c3_i));
  assign score_o = 4'(sum >= 5'd20 ? sum - 5'd20 : sum >= 5'd10 ? sum - 5'd10 : sum);
  // code 0 doubles as the empty-slot value, so only codes above King are flagged here
  assign illegal_o = (c1_i > CARD_KING) | (c2_i > CARD_KING) | (c3_i > CARD_KING);
endmodule

// File: rtl/baccarat_datapath.sv
// baccarat_datapath: captures dealt cards into six slots, scores both hands, flags protocol errors
module baccarat_datapath
  import baccarat_pkg::*;
(
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic [CARD_W-1:0] new_card,
  input  logic              load_pcard1,
  input  logic              load_pcard2,
  input  logic              load_pcard3,
  input  logic              load_dcard1,
  input  logic              load_dcard2,
  input  logic              load_dcard3,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [3:0]        pscore,
  output logic [3:0]        dscore,
  output logic [2:0]        cards_dealt,
  output logic              load_error
);
  logic [NUM_SLOTS-1:0] strb, valid_q, valid_d;
  logic [CARD_W-1:0]    card_q [NUM_SLOTS];
  logic [CARD_W-1:0]    card_d [NUM_SLOTS];
  logic [2:0]           cnt_q, cnt_d;
  logic                 err_q, err_d, p_ill, d_ill;
  assign strb = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) card_d[i] = strb[i] ? new_card : card_q[i];
    valid_d = valid_q | strb;
    cnt_d = popcount(valid_d);
    err_d = err_q | (popcount(strb) > 3'd1) | (|(strb & valid_q)) | (|strb & card_illegal(new_card));
  end
  always_ff @(posedge slow_clock or negedge resetb)
    if (!resetb) begin
      card_q <= '{default: '0};
      valid_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      card_q <= card_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  hand_score u_player (.c1_i(card_q[P1]), .c2_i(card_q[P2]), .c3_i(card_q[P3]), .score_o(pscore), .illegal_o(p_ill));
  hand_score u_dealer (.c1_i(card_q[D1]), .c2_i(card_q[D2]), .c3_i(card_q[D3]), .score_o(dscore), .illegal_o(d_ill));
  assign pcard1 = card_q[P1];
  assign pcard2 = card_q[P2];
  assign pcard3 = card_q[P3];
  assign dcard1 = card_q[D1];
  assign dcard2 = card_q[D2];
  assign dcard3 = card_q[D3];
  assign cards_dealt = cnt_q;
  // a stored out-of-range code always coincides with the error register being set
  assign load_error = err_q | p_ill | d_ill;
endmodule

// File: tb/tb_baccarat_datapath.sv
// tb_baccarat_datapath: directed and randomized checks against a card-rule model
module tb_baccarat_datapath;
  logic slow_clock = 0, resetb = 0;
  logic [3:0] new_card = 0;
  logic [5:0] strb = 0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic [2:0] cards_dealt;
  logic load_error;
  logic [3:0] dut_card [6];
  int n_chk = 0, n_fail = 0;
  int mcard [6];
  bit mvalid [6];
  bit merr;

  baccarat_datapath dut (
    .slow_clock(slow_clock), .resetb(resetb), .new_card(new_card),
    .load_pcard1(strb[0]), .load_pcard2(strb[1]), .load_pcard3(strb[2]),
    .load_dcard1(strb[3]), .load_dcard2(strb[4]), .load_dcard3(strb[5]),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .cards_dealt(cards_dealt), .load_error(load_error)
  );

  always #5 slow_clock = ~slow_clock;

  assign dut_card[0] = pcard1;
  assign dut_card[1] = pcard2;
  assign dut_card[2] = pcard3;
  assign dut_card[3] = dcard1;
  assign dut_card[4] = dcard2;
  assign dut_card[5] = dcard3;

  function automatic int mval(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int mscore(input int base);
    return (mval(mcard[base]) + mval(mcard[base+1]) + mval(mcard[base+2])) % 10;
  endfunction

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < 6; i++) n += int'(mvalid[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin
      mcard[i] = 0;
      mvalid[i] = 0;
    end
    merr = 0;
  endtask

  task automatic do_reset();
    resetb = 0;
    #2;
    model_clear();
    resetb = 1;
  endtask

  task automatic load(input logic [5:0] s, input logic [3:0] c);
    int n = 0;
    strb = s;
    new_card = c;
    @(posedge slow_clock);
    #1;
    strb = 0;
    for (int i = 0; i < 6; i++)
      if (s[i]) begin
        n++;
        if (mvalid[i]) merr = 1;
        if (c == 0 || c > 13) merr = 1;
        mcard[i] = int'(c);
        mvalid[i] = 1;
      end
    if (n > 1) merr = 1;
  endtask

  task automatic test_reset();
    resetb = 0;
    for (int k = 0; k < 4; k++) begin
      strb = 6'($urandom);
      new_card = 4'($urandom_range(1, 9));
      @(posedge slow_clock);
      #1;
      n_chk++;
      if ({pscore, dscore, cards_dealt, load_error} !== 12'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got ps=%0d ds=%0d cnt=%0d err=%0d required all 0", pscore, dscore, cards_dealt, load_error);
      end
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (dut_card[i] !== 4'd0) begin
          n_fail++;
          $display("FAIL reset_card%0d: got %0d required 0", i, dut_card[i]);
        end
      end
    end
    strb = 0;
    model_clear();
    resetb = 1;
    load(6'b000001, 4'd7);
    n_chk++;
    if (pcard1 !== 4'd7 || pscore !== 4'd7 || cards_dealt !== 3'd1) begin
      n_fail++;
      $display("FAIL first_load: got pcard1=%0d pscore=%0d cnt=%0d required 7 7 1", pcard1, pscore, cards_dealt);
    end
  endtask

  task automatic test_player_wrap();
    do_reset();
    load(6'b000001, 4'd9);
    load(6'b000010, 4'd8);
    n_chk++;
    if (pscore !== 4'd7) begin
      n_fail++;
      $display("FAIL player_wrap: got pscore=%0d required 7", pscore);
    end
    load(6'b000100, 4'd12);
    n_chk++;
    if (pscore !== 4'd7 || pcard3 !== 4'd12 || cards_dealt !== 3'd3 || load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL player_third: got ps=%0d p3=%0d cnt=%0d err=%0d required 7 12 3 0", pscore, pcard3, cards_dealt, load_error);
    end
  endtask

  task automatic test_dealer();
    do_reset();
    load(6'b001000, 4'd13);
    load(6'b010000, 4'd10);
    n_chk++;
    if (dscore !== 4'd0 || dcard1 !== 4'd13 || dcard2 !== 4'd10) begin
      n_fail++;
      $display("FAIL dealer_faces: got ds=%0d d1=%0d d2=%0d required 0 13 10", dscore, dcard1, dcard2);
    end
    load(6'b100000, 4'd5);
    n_chk++;
    if (dscore !== 4'd5) begin
      n_fail++;
      $display("FAIL dealer_third: got ds=%0d required 5", dscore);
    end
    do_reset();
    load(6'b001000, 4'd9);
    load(6'b010000, 4'd9);
    load(6'b100000, 4'd9);
    n_chk++;
    if (dscore !== 4'd7 || pscore !== 4'd0 || cards_dealt !== 3'd3) begin
      n_fail++;
      $display("FAIL dealer_27: got ds=%0d ps=%0d cnt=%0d required 7 0 3", dscore, pscore, cards_dealt);
    end
  endtask

  task automatic test_errors();
    do_reset();
    load(6'b001001, 4'd4);
    n_chk++;
    if (pcard1 !== 4'd4 || dcard1 !== 4'd4 || load_error !== 1'b1 || cards_dealt !== 3'd2) begin
      n_fail++;
      $display("FAIL multi_strobe: got p1=%0d d1=%0d err=%0d cnt=%0d required 4 4 1 2", pcard1, dcard1, load_error, cards_dealt);
    end
    do_reset();
    load(6'b000001, 4'd3);
    n_chk++;
    if (load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_load: got err=%0d required 0", load_error);
    end
    load(6'b000001, 4'd5);
    n_chk++;
    if (load_error !== 1'b1 || pcard1 !== 4'd5 || cards_dealt !== 3'd1 || pscore !== 4'd5) begin
      n_fail++;
      $display("FAIL reload: got err=%0d p1=%0d cnt=%0d ps=%0d required 1 5 1 5", load_error, pcard1, cards_dealt, pscore);
    end
    do_reset();
    load(6'b000010, 4'd15);
    n_chk++;
    if (load_error !== 1'b1 || pcard2 !== 4'd15 || pscore !== 4'd0) begin
      n_fail++;
      $display("FAIL illegal_15: got err=%0d p2=%0d ps=%0d required 1 15 0", load_error, pcard2, pscore);
    end
    do_reset();
    load(6'b010000, 4'd0);
    load(6'b100000, 4'd6);
    n_chk++;
    if (load_error !== 1'b1 || dscore !== 4'd6 || cards_dealt !== 3'd2) begin
      n_fail++;
      $display("FAIL illegal_0: got err=%0d ds=%0d cnt=%0d required 1 6 2", load_error, dscore, cards_dealt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(6'b000001, 4'd2);
    load(6'b001000, 4'd3);
    load(6'b000010, 4'd4);
    load(6'b010000, 4'd14);
    #2;
    resetb = 0;
    #1;
    n_chk++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore, cards_dealt, load_error} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got p=%0d,%0d d=%0d,%0d ps=%0d ds=%0d cnt=%0d err=%0d required all 0",
               pcard1, pcard2, dcard1, dcard2, pscore, dscore, cards_dealt, load_error);
    end
    #1;
    model_clear();
    resetb = 1;
    @(posedge slow_clock);
    #1;
  endtask

  task automatic test_random();
    logic [5:0] s;
    for (int h = 0; h < 30; h++) begin
      do_reset();
      for (int k = 0; k < $urandom_range(1, 8); k++) begin
        s = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
        load(s, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 6; i++) begin
          n_chk++;
          if (dut_card[i] !== 4'(mcard[i])) begin
            n_fail++;
            $display("FAIL rand_card%0d: got %0d required %0d", i, dut_card[i], mcard[i]);
          end
        end
        n_chk++;
        if (pscore !== 4'(mscore(0)) || dscore !== 4'(mscore(3)) || cards_dealt !== 3'(mcount()) || load_error !== merr) begin
          n_fail++;
          $display("FAIL rand_state: got ps=%0d ds=%0d cnt=%0d err=%0d required %0d %0d %0d %0d",
                   pscore, dscore, cards_dealt, load_error, mscore(0), mscore(3), mcount(), merr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_player_wrap();
    test_dealer();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
